can_rx_destuff_ctrl: RTL and testbench

- Sequences CAN receive bit destuffing for one node. Consumes raw sampled bus bits (one strobe per bit time) and detects start of frame.
- Removes stuff bits inside the stuffed frame region and flags stuff errors.
- Hands clean, valid-qualified bits to the frame decoder. The decoder controls when stuffing applies (stuff_en) and when the frame ends (frame_done).
- Sits between the bit-timing/sampling logic and the frame decoder.

---
 rtl/can_rx_destuff_ctrl.sv | 158 +++++++++++++++
 tb/tb_can_rx_destuff_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_destuff_ctrl.sv
// CAN receive bit destuffing sequencer: SOF detection, stuff-bit removal, stuff-error flagging.
// Optional DESTUFF_STATS_EN adds saturating stuff-bit and stuff-error counters.
module can_rx_destuff_ctrl #(
  parameter int STUFF_LEN = 5,
  parameter int IDLE_LEN  = 11,
  parameter int CNT_W     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sample_en,
  input  logic        rx_bit,
  input  logic        stuff_en,
  input  logic        frame_done,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        sof,
  output logic        stuff_err,
  output logic        busy,
  output logic [1:0]  state
`ifdef DESTUFF_STATS_EN
  ,
  output logic [15:0] stuff_bit_cnt,
  output logic [15:0] stuff_err_cnt
`endif
);

  // state   | meaning
  // IDLE    | bus idle, waiting for a dominant SOF bit
  // ACTIVE  | inside stuffed region, counting runs and removing stuff bits
  // NOSTUFF | past the stuffed region, bits pass straight through
  // ERROR   | stuff error seen, waiting for IDLE_LEN recessive bits
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_NOSTUFF = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STUFF_L = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] IDLE_L  = CNT_W'(IDLE_LEN);

  state_t           state_q, state_d;
  logic             last_bit, last_bit_d;
  logic [CNT_W-1:0] run_cnt, run_cnt_d;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_d;
  logic             bit_out_d, bit_valid_d, sof_d, stuff_err_d;
  logic             stuff_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      last_bit  <= 1'b1;
      run_cnt   <= '0;
      idle_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_bit  <= last_bit_d;
      run_cnt   <= run_cnt_d;
      idle_cnt  <= idle_cnt_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      sof       <= sof_d;
      stuff_err <= stuff_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_bit_d  = last_bit;
    run_cnt_d   = run_cnt;
    idle_cnt_d  = idle_cnt;
    bit_out_d   = bit_out;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;
    stuff_drop  = 1'b0;

    // frame_done wins over a coincident sample, except while recovering from an error
    if (frame_done && (state_q != ST_ERROR)) begin
      state_d   = ST_IDLE;
      run_cnt_d = '0;
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_bit) begin
            state_d     = ST_ACTIVE;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b1;
            sof_d       = 1'b1;
            last_bit_d  = 1'b0;
            run_cnt_d   = CNT_ONE;
          end
        end
        ST_ACTIVE: begin
          // a pending stuff bit is checked even once stuff_en has dropped
          if (run_cnt == STUFF_L) begin
            if (rx_bit != last_bit) begin
              stuff_drop = 1'b1;
              last_bit_d = rx_bit;
              run_cnt_d  = CNT_ONE;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = ST_ERROR;
              idle_cnt_d  = rx_bit ? CNT_ONE : '0;
            end
          end else if (stuff_en) begin
            bit_out_d   = rx_bit;
            bit_valid_d = 1'b1;
            if (rx_bit == last_bit) begin
              run_cnt_d = run_cnt + CNT_ONE;
            end else begin
              run_cnt_d  = CNT_ONE;
              last_bit_d = rx_bit;
            end
          end else begin
            state_d     = ST_NOSTUFF;
            bit_out_d   = rx_bit;
            bit_valid_d = 1'b1;
          end
        end
        ST_NOSTUFF: begin
          bit_out_d   = rx_bit;
          bit_valid_d = 1'b1;
        end
        ST_ERROR: begin
          if (rx_bit) begin
            idle_cnt_d = (idle_cnt >= IDLE_L) ? IDLE_L : idle_cnt + CNT_ONE;
            if (idle_cnt_d == IDLE_L) state_d = ST_IDLE;
          end else begin
            idle_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef DESTUFF_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stuff_bit_cnt <= '0;
      stuff_err_cnt <= '0;
    end else begin
      if (stuff_drop && (stuff_bit_cnt != 16'hFFFF)) stuff_bit_cnt <= stuff_bit_cnt + 16'd1;
      if (stuff_err_d && (stuff_err_cnt != 16'hFFFF)) stuff_err_cnt <= stuff_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_rx_destuff_ctrl.sv
// Self-checking bench for can_rx_destuff_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the destuffing rules.
module tb_can_rx_destuff_ctrl;
  localparam int STUFF_LEN = 5;
  localparam int IDLE_LEN  = 11;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic sample_en = 1'b0, rx_bit = 1'b1, stuff_en = 1'b0, frame_done = 1'b0;
  logic bit_out, bit_valid, sof, stuff_err, busy;
  logic [1:0] state;
`ifdef DESTUFF_STATS_EN
  logic [15:0] stuff_bit_cnt, stuff_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  can_rx_destuff_ctrl #(.STUFF_LEN(STUFF_LEN), .IDLE_LEN(IDLE_LEN), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .sample_en(sample_en), .rx_bit(rx_bit), .stuff_en(stuff_en),
    .frame_done(frame_done), .bit_out(bit_out), .bit_valid(bit_valid), .sof(sof),
    .stuff_err(stuff_err), .busy(busy), .state(state)
`ifdef DESTUFF_STATS_EN
    , .stuff_bit_cnt(stuff_bit_cnt), .stuff_err_cnt(stuff_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic rx, input logic se, input logic st, input logic fd);
    @(negedge CLK);
    rx_bit = rx; sample_en = se; stuff_en = st; frame_done = fd;
    @(posedge CLK);
    #1;
    sample_en = 1'b0; frame_done = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; sample_en = 1'b0; frame_done = 1'b0; stuff_en = 1'b1; rx_bit = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({bit_out, bit_valid, sof, stuff_err} !== 4'b0) begin errors++; $display("FAIL rst_outs got=%b exp=0000", {bit_out, bit_valid, sof, stuff_err}); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_sof();
    apply_reset();
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    checks++; if (bit_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL sof_idle_recessive got valid=%b state=%0d exp valid=0 state=0", bit_valid, state); end
    drive(0, 1, 1, 0);
    checks++; if ({sof, bit_valid, bit_out} !== 3'b110) begin errors++; $display("FAIL sof_pulse got sof/valid/out=%b exp=110", {sof, bit_valid, bit_out}); end
    checks++; if (state !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL sof_state got state=%0d busy=%b exp 1/1", state, busy); end
    drive(0, 0, 1, 0);
    checks++; if ({sof, bit_valid} !== 2'b00) begin errors++; $display("FAIL sof_one_cycle got sof/valid=%b exp=00", {sof, bit_valid}); end
  endtask

  task automatic test_destuff();
    int nz;
    apply_reset();
    drive(0, 1, 1, 0);
    nz = (bit_valid && !bit_out) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0);
      if (bit_valid && !bit_out) nz++;
    end
    checks++; if (nz !== 5) begin errors++; $display("FAIL destuff_zero_count got=%0d exp=5", nz); end
    drive(1, 1, 1, 0);
    checks++; if (bit_valid !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL destuff_drop got valid=%b state=%0d exp 0/1", bit_valid, state); end
    drive(1, 1, 1, 0);
    checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin errors++; $display("FAIL destuff_next got valid=%b out=%b exp 1/1", bit_valid, bit_out); end
  endtask

  task automatic test_stuff_err();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    checks++; if (stuff_err !== 1'b1 || state !== 2'd3 || bit_valid !== 1'b0) begin errors++; $display("FAIL stuff_err got err=%b state=%0d valid=%b exp 1/3/0", stuff_err, state, bit_valid); end
    drive(1, 0, 1, 1);
    checks++; if (stuff_err !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL err_fd_ignored got err=%b state=%0d exp 0/3", stuff_err, state); end
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 1, 0);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL err_restart got state=%0d exp=3", state); end
    drive(1, 1, 1, 0);
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL err_recover got state=%0d busy=%b exp 0/0", state, busy); end
  endtask

  task automatic test_nostuff();
    int nvalid;
    apply_reset();
    drive(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0);
    drive(0, 1, 0, 0);
    checks++; if (bit_valid !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL late_stuff_drop got valid=%b state=%0d exp 0/1", bit_valid, state); end
    drive(1, 1, 0, 0);
    checks++; if (bit_valid !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL enter_nostuff got valid=%b state=%0d exp 1/2", bit_valid, state); end
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0);
      if (bit_valid && bit_out && !stuff_err) nvalid++;
    end
    checks++; if (nvalid !== 6 || state !== 2'd2) begin errors++; $display("FAIL nostuff_pass got valid=%0d state=%0d exp 6/2", nvalid, state); end
  endtask

  task automatic test_frame_done();
    apply_reset();
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 1);
    checks++; if (bit_valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL fd_priority got valid=%b state=%0d exp 0/0", bit_valid, state); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0);
    #2 RST = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || {bit_out, bit_valid, sof, stuff_err, busy} !== 5'b0) begin errors++; $display("FAIL rst_mid got state=%0d outs=%b exp 0/00000", state, {bit_out, bit_valid, sof, stuff_err, busy}); end
    @(negedge CLK); RST = 1'b0;
  endtask

`ifdef DESTUFF_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    checks++; if (stuff_bit_cnt !== 16'd2 || stuff_err_cnt !== 16'd1) begin errors++; $display("FAIL stats got bits=%0d errs=%0d exp 2/1", stuff_bit_cnt, stuff_err_cnt); end
  endtask
`endif

  // Reference model: frame bits subject to stuffing are kept in a queue, the run length
  // is re-derived from its tail; error recovery looks at the tail of recessive bits.
  int   m_state;
  bit   q_frame[$];
  bit   q_err[$];
  logic e_bo, e_bv, e_sof, e_err;
  int   m_sbits, m_serrs;

  function automatic int tail_run();
    int n = 0;
    for (int i = q_frame.size() - 1; i >= 0; i--) begin
      if (q_frame[i] == q_frame[q_frame.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic int tail_ones();
    int n = 0;
    for (int i = q_err.size() - 1; i >= 0; i--) begin
      if (q_err[i]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step(input logic rx, input logic se, input logic st, input logic fd);
    e_bv = 0; e_sof = 0; e_err = 0;
    if (fd && m_state != 3) begin
      m_state = 0;
      q_frame.delete();
    end else if (se) begin
      if (m_state == 0) begin
        if (!rx) begin
          m_state = 1; q_frame.delete(); q_frame.push_back(1'b0);
          e_bo = 0; e_bv = 1; e_sof = 1;
        end
      end else if (m_state == 1) begin
        if (tail_run() == STUFF_LEN) begin
          if (rx != q_frame[q_frame.size() - 1]) begin
            q_frame.push_back(rx); m_sbits++;
          end else begin
            e_err = 1; m_state = 3; m_serrs++;
            q_err.delete(); q_err.push_back(rx);
          end
        end else if (st) begin
          q_frame.push_back(rx); e_bo = rx; e_bv = 1;
        end else begin
          m_state = 2; e_bo = rx; e_bv = 1;
        end
      end else if (m_state == 2) begin
        e_bo = rx; e_bv = 1;
      end else begin
        q_err.push_back(rx);
        if (tail_ones() >= IDLE_LEN) m_state = 0;
      end
    end
  endtask

  task automatic test_random();
    logic rx, se, st, fd;
    apply_reset();
    m_state = 0; q_frame.delete(); q_err.delete();
    e_bo = 0; e_bv = 0; e_sof = 0; e_err = 0; m_sbits = 0; m_serrs = 0;
    rx = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      se = ($urandom_range(3) != 0);
      if (m_state == 3) rx = ($urandom_range(19) != 0);
      else if ($urandom_range(9) < 2) rx = ~rx;
      st = ($urandom_range(15) != 0);
      fd = ($urandom_range(39) == 0);
      drive(rx, se, st, fd);
      model_step(rx, se, st, fd);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, state, m_state); end
      checks++; if (busy !== (m_state != 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_state != 0); end
      checks++; if ({bit_valid, sof, stuff_err} !== {e_bv, e_sof, e_err}) begin errors++; $display("FAIL rnd_pulses n=%0d got=%b exp=%b", n, {bit_valid, sof, stuff_err}, {e_bv, e_sof, e_err}); end
      checks++; if (bit_out !== e_bo) begin errors++; $display("FAIL rnd_bit_out n=%0d got=%b exp=%b", n, bit_out, e_bo); end
`ifdef DESTUFF_STATS_EN
      checks++; if (stuff_bit_cnt !== 16'(m_sbits) || stuff_err_cnt !== 16'(m_serrs)) begin errors++; $display("FAIL rnd_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stuff_bit_cnt, stuff_err_cnt, m_sbits, m_serrs); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sof();
    test_destuff();
    test_stuff_err();
    test_nostuff();
    test_frame_done();
    test_reset_mid();
`ifdef DESTUFF_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
